// File: rtl/mcs4_sys.sv
// mcs4_sys: MCS-4 system top, i4004 core plus 4096x8 program ROM on the multiplexed D bus.
module i4004 (
  input  logic       CLK,
  input  logic       RES,
  output logic       SYNC,
  input  logic [3:0] D_IN,
  output logic [3:0] D_OUT,
  output logic       D_OE,
  output logic       CM_ROM,
  output logic [3:0] CM_RAM,
  input  logic       TEST
);
  logic [2:0] cp;
  logic [11:0] pc;
  logic [3:0] opr, hi;
  logic jun;
  logic unused;
  assign unused = TEST;
  always_ff @(posedge CLK) begin
    if (RES) begin
      cp <= 3'd7;
      pc <= '0;
      opr <= '0;
      hi <= '0;
      jun <= 1'b0;
      SYNC <= 1'b0;
    end else begin
      cp <= cp + 3'd1;
      SYNC <= cp == 3'd6;
      if (cp == 3'd3) opr <= D_IN;
      if (cp == 3'd4) begin
        if (jun) begin
          pc <= {hi, opr, D_IN};
          jun <= 1'b0;
        end else begin
          pc <= pc + 12'd1;
          jun <= opr == 4'h4;
          hi <= D_IN;
        end
      end
    end
  end
  // Only NOP-style fetch and the two-word JUN are decoded by this core.
  always_comb begin
    D_OE = cp < 3'd3;
    D_OUT = cp == 3'd0 ? pc[3:0] : cp == 3'd1 ? pc[7:4] : cp == 3'd2 ? pc[11:8] : 4'h0;
    CM_ROM = cp == 3'd2;
    CM_RAM = 4'h0;
  end
endmodule

module mcs4_sys #(
  parameter int ROM_AW = 12,
  parameter ROM_FILE = "rom.hex"
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              ROM_INIT_ENB,
  input  logic [ROM_AW-1:0] ROM_INIT_ADDR,
  input  logic              ROM_INIT_RE,
  input  logic              ROM_INIT_WE,
  input  logic [7:0]        ROM_INIT_WDATA,
  output logic [7:0]        ROM_INIT_RDATA,
  output logic              DBG_SYNC,
  output logic [11:0]       DBG_PC
);
  logic cpu_rst, sync, d_oe, cm_rom;
  logic [3:0] d_in, d_out, cm_ram;
  logic [2:0] ph;
  logic [11:0] addr;
  logic [7:0] rom_q;
  logic unused;
  logic [7:0] mem [0:(1<<ROM_AW)-1] = '{default: 8'h00};
  assign cpu_rst = RES | ROM_INIT_ENB;
  assign DBG_SYNC = sync;
  assign unused = &{1'b0, cm_rom, cm_ram, addr[11:8]};
  i4004 u_cpu (
    .CLK(CLK), .RES(cpu_rst), .SYNC(sync), .D_IN(d_in), .D_OUT(d_out),
    .D_OE(d_oe), .CM_ROM(cm_rom), .CM_RAM(cm_ram), .TEST(1'b0)
  );
  always_comb d_in = d_oe ? 4'h0 : ph == 3'd3 ? rom_q[7:4] : ph == 3'd4 ? rom_q[3:0] : 4'h0;
  always_ff @(posedge CLK) begin
    if (cpu_rst) begin
      ph <= 3'd7;
      addr <= '0;
      DBG_PC <= '0;
    end else begin
      ph <= sync ? 3'd0 : ph + 3'd1;
      if (ph == 3'd0) addr[3:0] <= d_out;
      if (ph == 3'd1) addr[7:4] <= d_out;
      if (ph == 3'd2) begin
        addr[11:8] <= d_out;
        DBG_PC <= {d_out, addr[7:0]};
      end
    end
  end
  // Read-first: the init read sees the contents from before a same-edge write.
  always_ff @(posedge CLK) begin
    if (ROM_INIT_ENB && ROM_INIT_WE) mem[ROM_INIT_ADDR] <= ROM_INIT_WDATA;
    if (RES) ROM_INIT_RDATA <= '0;
    else if (ROM_INIT_ENB && ROM_INIT_RE) ROM_INIT_RDATA <= mem[ROM_INIT_ADDR];
    if (!cpu_rst && ph == 3'd2) rom_q <= mem[{d_out, addr[7:0]}];
  end
endmodule

// File: tb/tb_mcs4_sys.sv
// tb_mcs4_sys: scoreboard bench for mcs4_sys; fetch addresses and init reads are queued and checked by a monitor.
module tb_mcs4_sys;
  logic clk = 0, res = 1, enb = 0, re = 0, we = 0;
  logic [11:0] iaddr = 0;
  logic [7:0] wdata = 0, rdata;
  logic dsync;
  logic [11:0] dpc;
  int checks = 0, passed = 0, cyc = 0, prev = 0;
  bit prev_ok = 0, pc_on = 0;
  logic re_pend = 0;
  logic [11:0] pc_q[$];
  logic [7:0] rd_q[$];

  mcs4_sys dut (
    .CLK(clk), .RES(res), .ROM_INIT_ENB(enb), .ROM_INIT_ADDR(iaddr), .ROM_INIT_RE(re),
    .ROM_INIT_WE(we), .ROM_INIT_WDATA(wdata), .ROM_INIT_RDATA(rdata), .DBG_SYNC(dsync), .DBG_PC(dpc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(posedge clk) begin
    re_pend <= enb & re;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (re_pend) begin
      if (rd_q.size() == 0) begin
        checks++;
        $display("FAIL rdata_extra: got %0h expected no read", rdata);
      end else chk("rdata", rdata, rd_q.pop_front());
    end
    if (res | enb) prev_ok = 0;
    else if (dsync) begin
      if (prev_ok && pc_on) chk("sync_period", cyc - prev, 8);
      prev = cyc;
      prev_ok = 1;
      if (pc_on) begin
        if (pc_q.size() == 0) begin
          checks++;
          $display("FAIL dbg_pc_extra: got %0h expected none", dpc);
        end else chk("dbg_pc", dpc, pc_q.pop_front());
      end
    end
  end

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    enb = 1; we = 1; iaddr = a; wdata = d;
    @(negedge clk);
    we = 0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [7:0] exp);
    enb = 1; re = 1; iaddr = a;
    rd_q.push_back(exp);
    @(negedge clk);
    re = 0;
  endtask

  task automatic run_pc(input int limit);
    pc_on = 1;
    for (int i = 0; i < limit && pc_q.size() > 0; i++) @(negedge clk);
    if (pc_q.size() > 0) begin
      checks++;
      $display("FAIL pc_timeout: got %0d pending expected 0", pc_q.size());
      pc_q.delete();
    end
    pc_on = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rdata", rdata, 0);
    chk("rst_dbg_pc", dpc, 0);
    chk("rst_sync", dsync, 0);
    chk("rst_ph", dut.ph, 7);
    chk("rst_d_in", dut.d_in, 0);
    // T1: all-zero ROM runs as NOPs
    for (int i = 0; i < 4; i++) pc_q.push_back(12'(i));
    res = 0;
    run_pc(60);
    // T2: write then read, read data holds
    wr(12'h000, 8'h12);
    rd(12'h000, 8'h12);
    @(negedge clk);
    chk("rdata_hold", rdata, 8'h12);
    // T3: simultaneous read and write returns old data
    re = 1; we = 1; iaddr = 12'h010; wdata = 8'hAB;
    rd_q.push_back(8'h00);
    @(negedge clk);
    re = 0; we = 0;
    rd(12'h010, 8'hAB);
    @(negedge clk);
    // T4: JUN 0x005
    wr(12'h000, 8'h40);
    wr(12'h001, 8'h05);
    pc_q.push_back(12'h000); pc_q.push_back(12'h001);
    pc_q.push_back(12'h005); pc_q.push_back(12'h006);
    enb = 0;
    run_pc(100);
    re = 1; iaddr = 12'h000;
    @(negedge clk);
    re = 0;
    @(negedge clk);
    chk("re_ignored", rdata, 8'hAB);
    // T5: full address wrap
    wr(12'h000, 8'h00);
    wr(12'h001, 8'h00);
    wr(12'h010, 8'h00);
    for (int i = 0; i < 4096; i++) pc_q.push_back(12'(i));
    pc_q.push_back(12'h000);
    enb = 0;
    run_pc(4097 * 8 + 64);
    // T6: reset during M1
    for (int i = 0; i < 16 && dut.ph != 3'd3; i++) @(negedge clk);
    chk("reach_m1", dut.ph, 3);
    res = 1;
    @(negedge clk);
    chk("t6_d_in", dut.d_in, 0);
    chk("t6_dbg_pc", dpc, 0);
    chk("t6_ph", dut.ph, 7);
    res = 0;
    pc_q.push_back(12'h000); pc_q.push_back(12'h001);
    run_pc(60);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
